delay_ctrl: RTL and testbench

Runtime-configurable sample delay controller: sequences a circular-buffer delay line, accepting samples on a strobe and emitting each sample exactly D accepted samples later. Replaces fixed-length shift delays where the delay must change at runtime. Handles priming after reset or reconfiguration, so no stale or uninitialised data ever reaches the output. Sits between the sample source and downstream DSP on the sample strobe.

---
 rtl/delay_pkg.sv | 25 ++
 rtl/delay_ctrl_if.sv | 28 ++
 rtl/circ_buf.sv | 24 ++
 rtl/delay_ctrl.sv | 120 ++++++++++++
 tb/tb_delay_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// Shared types and constants for the runtime-configurable sample delay controller.
package delay_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_MAX_DELAY     = 64;
  localparam int DEF_DEFAULT_DELAY = 20;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// Sample stream, configuration and status signals of the delay controller.
interface delay_ctrl_if #(
  parameter int DATA_WIDTH = delay_pkg::DEF_DATA_WIDTH,
  parameter int DELAY_W    = delay_pkg::clog2(delay_pkg::DEF_MAX_DELAY + 1)
) ();

  logic                  en;
  logic                  cfg_load;
  logic [DELAY_W-1:0]    cfg_delay;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  cfg_err;
  logic [DELAY_W-1:0]    cur_delay;

  modport master (
    output en, cfg_load, cfg_delay, in_valid, data_in,
    input  out_valid, data_out, busy, cfg_err, cur_delay
  );

  modport slave (
    input  en, cfg_load, cfg_delay, in_valid, data_in,
    output out_valid, data_out, busy, cfg_err, cur_delay
  );

endinterface

// File: rtl/circ_buf.sv
// Delay-line storage: one write port, one registered read port, no reset.
module circ_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Same-address read and write return the old word, which D == DEPTH relies on.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_ctrl.sv
// Circular-buffer delay line sequencer with runtime delay reconfiguration and priming.
//
// state | meaning
// PRIME | fewer than cur_delay samples accepted since config; no output
// RUN   | every accepted sample emits the sample cur_delay accepts older
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_DELAY     = DEF_MAX_DELAY,
  parameter int DEFAULT_DELAY = DEF_DEFAULT_DELAY,
  parameter int DELAY_W       = clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  delay_ctrl_if.slave   bus
);

  localparam int PTR_W = (MAX_DELAY > 1) ? clog2(MAX_DELAY) : 1;

  state_t                state;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_addr;
  logic [DELAY_W:0]      rd_diff;
  logic [DELAY_W-1:0]    fill;
  logic [DELAY_W-1:0]    cur_delay;
  logic                  out_valid;
  logic                  cfg_err;
  logic                  busy;
  logic                  has_out;
  logic [DATA_WIDTH-1:0] rd_data;

  logic accept;
  logic cfg_in_range;
  logic cfg_ok;
  logic cfg_bad;
  logic emit;

  assign accept       = bus.en & bus.in_valid;
  assign cfg_in_range = (bus.cfg_delay != '0) && (bus.cfg_delay <= DELAY_W'(MAX_DELAY));
  assign cfg_ok       = bus.en & bus.cfg_load & cfg_in_range;
  assign cfg_bad      = bus.en & bus.cfg_load & ~cfg_in_range;
  // A valid config on the same cycle turns the sample into n=0, so it never emits.
  assign emit         = accept & ~cfg_ok & (state == RUN);

  always_comb begin
    rd_diff = (DELAY_W+1)'(wr_ptr) - (DELAY_W+1)'(cur_delay);
    if (rd_diff[DELAY_W]) rd_diff = rd_diff + (DELAY_W+1)'(MAX_DELAY);
  end

  assign rd_addr    = PTR_W'(rd_diff);
  assign wr_ptr_nxt = (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr + 1'b1;

  circ_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DELAY),
    .ADDR_W     (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (emit),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      wr_ptr    <= '0;
      fill      <= '0;
      cur_delay <= DELAY_W'(DEFAULT_DELAY);
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b1;
      has_out   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      cfg_err   <= cfg_bad;
      if (accept) wr_ptr <= wr_ptr_nxt;
      if (cfg_ok) begin
        cur_delay <= bus.cfg_delay;
        if (accept && bus.cfg_delay == DELAY_W'(1)) begin
          fill  <= DELAY_W'(1);
          state <= RUN;
          busy  <= 1'b0;
        end else begin
          fill  <= accept ? DELAY_W'(1) : '0;
          state <= PRIME;
          busy  <= 1'b1;
        end
      end else if (accept) begin
        case (state)
          PRIME: begin
            fill <= fill + 1'b1;
            if (fill + 1'b1 == cur_delay) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end
          RUN: begin
            out_valid <= 1'b1;
            has_out   <= 1'b1;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

  // The buffer has no reset, so data_out is forced to zero until a first emit.
  assign bus.data_out  = has_out ? rd_data : '0;
  assign bus.out_valid = out_valid;
  assign bus.cfg_err   = cfg_err;
  assign bus.busy      = busy;
  assign bus.cur_delay = cur_delay;

endmodule

// File: tb/tb_delay_ctrl.sv
// Scoreboard bench for delay_ctrl: the driver queues expected outputs, a monitor pops them.
module tb_delay_ctrl;
  import delay_pkg::*;

  localparam int DW   = 16;
  localparam int MAXD = 64;
  localparam int DEFD = 20;
  localparam int DLW  = clog2(MAXD + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  delay_ctrl_if #(.DATA_WIDTH(DW), .DELAY_W(DLW)) bus ();

  delay_ctrl #(
    .DATA_WIDTH    (DW),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("out_valid_missing_cycle", 32'(cyc), 32'(e.due));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 32'(cyc), 32'(e.due));
          chk("data_out", 32'(bus.data_out), e.data);
        end
      end
    end
  end

  task automatic step(input bit v, input int d, input bit cl, input int cd,
                      input bit eo, input int ed);
    exp_t e;
    bus.in_valid  = v;
    bus.data_in   = DW'(d);
    bus.cfg_load  = cl;
    bus.cfg_delay = DLW'(cd);
    if (eo) begin
      e.due  = cyc + 1;
      e.data = 32'(ed);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_load = 1'b0;
  endtask

  task automatic send(input int d);
    step(1'b1, d, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic send_exp(input int d, input int ed);
    step(1'b1, d, 1'b0, 0, 1'b1, ed);
  endtask

  task automatic cfg(input int cd);
    step(1'b0, 0, 1'b1, cd, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1);
  end

  initial begin
    bus.en        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.cfg_load  = 1'b0;
    bus.cfg_delay = '0;
    repeat (2) @(negedge clk);

    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd1);
    chk("reset_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("reset_cur_delay", 32'(bus.cur_delay), 32'd20);
    rst_n = 1'b1;
    idle(1);

    // basic delay D=3
    cfg(3);
    chk("basic_cur_delay", 32'(bus.cur_delay), 32'd3);
    chk("basic_busy_after_cfg", 32'(bus.busy), 32'd1);
    send(1);
    send(2);
    chk("basic_busy_after_2", 32'(bus.busy), 32'd1);
    send(3);
    chk("basic_busy_after_3", 32'(bus.busy), 32'd0);
    send_exp(4, 1);
    send_exp(5, 2);
    idle(2);

    // gapped input with en dropped, D=2
    cfg(2);
    send(10);
    idle(1);
    send(20);
    idle(3);
    bus.en        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = DW'(99);
    bus.cfg_load  = 1'b1;
    bus.cfg_delay = DLW'(5);
    idle(2);
    bus.in_valid  = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.en        = 1'b1;
    chk("en_off_cur_delay", 32'(bus.cur_delay), 32'd2);
    chk("en_off_cfg_err", 32'(bus.cfg_err), 32'd0);
    send_exp(30, 10);
    idle(2);
    send_exp(40, 20);
    idle(2);

    // wrap and max delay
    cfg(64);
    for (int k = 0; k < 200; k++) begin
      if (k >= 64) send_exp(k, k - 64);
      else send(k);
      if (k == 62) chk("max_busy_at_63", 32'(bus.busy), 32'd1);
      if (k == 63) chk("max_busy_at_64", 32'(bus.busy), 32'd0);
    end
    idle(2);
    cfg(1);
    for (int k = 0; k < 10; k++) begin
      if (k >= 1) send_exp(1000 + k, 999 + k);
      else send(1000 + k);
    end
    idle(2);

    // reconfig mid-run, coincident with an accept
    cfg(3);
    send(50);
    send(51);
    send(52);
    send_exp(53, 50);
    step(1'b1, 100, 1'b1, 2, 1'b0, 0);
    chk("reconfig_busy", 32'(bus.busy), 32'd1);
    chk("reconfig_cur_delay", 32'(bus.cur_delay), 32'd2);
    send(101);
    chk("reconfig_busy_done", 32'(bus.busy), 32'd0);
    send_exp(102, 100);
    send_exp(103, 101);
    step(1'b1, 200, 1'b1, 1, 1'b0, 0);
    chk("d1_coincident_busy", 32'(bus.busy), 32'd0);
    send_exp(201, 200);

    // illegal configs keep the stream running under the old delay
    step(1'b1, 202, 1'b1, 0, 1'b1, 201);
    chk("illegal0_cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("illegal0_cur_delay", 32'(bus.cur_delay), 32'd1);
    idle(1);
    chk("cfg_err_pulse_end", 32'(bus.cfg_err), 32'd0);
    step(1'b1, 203, 1'b1, 65, 1'b1, 202);
    chk("illegal65_cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("illegal65_cur_delay", 32'(bus.cur_delay), 32'd1);
    chk("illegal65_busy", 32'(bus.busy), 32'd0);
    send_exp(204, 203);
    step(1'b1, 205, 1'b1, 1, 1'b0, 0);
    send_exp(206, 205);

    // async reset between edges while a pulse is showing
    send_exp(301, 206);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data_out", 32'(bus.data_out), 32'd0);
    chk("arst_cur_delay", 32'(bus.cur_delay), 32'd20);
    chk("arst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) send(500 + k);
    send_exp(520, 500);
    idle(3);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
